// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor, LSB first.
// One full-adder slice plus a carry flip-flop, iterated over WIDTH cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             carry_next;
  logic             last_bit;
  logic             accept;

  assign s_bit      = op_a[0] ^ op_b[0] ^ carry;
  assign carry_next = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
  assign last_bit   = (cnt == CW'(WIDTH - 1));
  // Start is honoured in IDLE and in DONE (back-to-back), never while running.
  assign accept     = start && (state != RUN);

  // New sum bits enter from the MSB side so the LSB ends up at bit 0.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign result_next = s_bit;
    end else begin : g_wide
      assign result_next = {s_bit, result[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE_S;
      DONE_S:  state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE_S);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a   <= op_a >> 1;
      op_b   <= op_b >> 1;
      carry  <= carry_next;
      cnt    <= cnt + 1'b1;
      result <= result_next;
      if (last_bit) begin
        sum  <= result_next;
        cout <= carry_next;
        ovf  <= carry ^ carry_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 instance for the main scenarios,
// plus a WIDTH=1 instance for the single-bit corner.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       start1 = 1'b0;
  logic       sub1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // Issues one operation and waits (bounded) for done. lat is the number of
  // negedges after the start edge at which done was seen; bcyc counts busy cycles.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                       input bit noise, output logic [7:0] rs, output logic rc,
                       output logic ro, output int lat, output int bcyc, output bit got);
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0; lat = -1; bcyc = 0; rs = 'x; rc = 1'bx; ro = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1; lat = i; rs = sum; rc = cout; ro = ovf; start = 1'b0;
        break;
      end
      if (busy) bcyc++;
      if (noise) begin
        start = i[0]; a = 8'hAA; b = 8'h55; sub = ~ts;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {cout, ovf}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_quiet got busy=%b done=%b want 0 0", busy, done); end
    $display("test_reset complete");
  endtask

  task automatic test_add();
    logic [7:0] rs; logic rc, ro; int lat, bcyc; bit got;
    do_op(8'h3C, 8'h0F, 1'b0, 1'b0, rs, rc, ro, lat, bcyc, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL add_done_seen got %b want 1", got); end
    checks++; if (lat != 8) begin errors++; $display("FAIL add_latency got %0d want 8", lat); end
    checks++; if (bcyc != 8) begin errors++; $display("FAIL add_busy_width got %0d want 8", bcyc); end
    checks++; if ({rs, rc, ro} !== {8'h4B, 2'b00}) begin errors++; $display("FAIL add_3C_0F got sum=%h c=%b v=%b want 4B 0 0", rs, rc, ro); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
    checks++; if (sum !== 8'h4B) begin errors++; $display("FAIL sum_held got %h want 4B", sum); end
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat, bcyc, got);
    checks++; if ({rs, rc, ro} !== {8'h00, 2'b10}) begin errors++; $display("FAIL add_FF_01 got sum=%h c=%b v=%b want 00 1 0", rs, rc, ro); end
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat, bcyc, got);
    checks++; if ({rs, rc, ro} !== {8'h80, 2'b01}) begin errors++; $display("FAIL add_7F_01 got sum=%h c=%b v=%b want 80 0 1", rs, rc, ro); end
    $display("test_add complete");
  endtask

  task automatic test_sub();
    logic [7:0] rs; logic rc, ro; int lat, bcyc; bit got;
    do_op(8'h05, 8'h07, 1'b1, 1'b0, rs, rc, ro, lat, bcyc, got);
    checks++; if ({rs, rc, ro} !== {8'hFE, 2'b00}) begin errors++; $display("FAIL sub_05_07 got sum=%h c=%b v=%b want FE 0 0", rs, rc, ro); end
    do_op(8'h80, 8'h01, 1'b1, 1'b0, rs, rc, ro, lat, bcyc, got);
    checks++; if ({rs, rc, ro} !== {8'h7F, 2'b11}) begin errors++; $display("FAIL sub_80_01 got sum=%h c=%b v=%b want 7F 1 1", rs, rc, ro); end
    $display("test_sub complete");
  endtask

  task automatic test_busy_ignore();
    logic [7:0] rs; logic rc, ro; int lat, bcyc; bit got;
    do_op(8'h21, 8'h13, 1'b0, 1'b1, rs, rc, ro, lat, bcyc, got);
    checks++; if (lat != 8) begin errors++; $display("FAIL ignore_latency got %0d want 8", lat); end
    checks++; if (bcyc != 8) begin errors++; $display("FAIL ignore_busy_width got %0d want 8", bcyc); end
    checks++; if ({rs, rc, ro} !== {8'h34, 2'b00}) begin errors++; $display("FAIL ignore_result got sum=%h c=%b v=%b want 34 0 0", rs, rc, ro); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got busy=%b want 0", busy); end
    $display("test_busy_ignore complete");
  endtask

  task automatic test_abort();
    logic [7:0] rs; logic rc, ro; int lat, bcyc; bit got; int spurious;
    @(negedge clk);
    a = 8'h99; b = 8'h11; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL abort_sum got %h want 00", sum); end
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) spurious++;
      @(negedge clk);
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", spurious); end
    do_op(8'h64, 8'h14, 1'b1, 1'b0, rs, rc, ro, lat, bcyc, got);
    checks++; if ({rs, rc, ro} !== {8'h50, 2'b10}) begin errors++; $display("FAIL after_abort got sum=%h c=%b v=%b want 50 1 0", rs, rc, ro); end
    $display("test_abort complete");
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h50; b = 8'h50;
    for (int i = 0; i < 20; i++) begin
      if (done) begin first = i; break; end
      @(negedge clk);
    end
    checks++; if (first != 8) begin errors++; $display("FAIL b2b_first_latency got %0d want 8", first); end
    checks++; if (sum !== 8'h46) begin errors++; $display("FAIL b2b_first_sum got %h want 46", sum); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_no_gap got busy=%b done=%b want 1 0", busy, done); end
    start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (done) begin second = j; break; end
      @(negedge clk);
    end
    checks++; if (second != 8) begin errors++; $display("FAIL b2b_second_latency got %0d want 8", second); end
    checks++; if ({sum, cout, ovf} !== {8'hA0, 2'b01}) begin errors++; $display("FAIL b2b_second got sum=%h c=%b v=%b want A0 0 1", sum, cout, ovf); end
    @(negedge clk);
    $display("test_back_to_back complete");
  endtask

  task automatic test_width1();
    // 1-bit signed: -1 + -1 overflows; carry in is 0, cout is 1.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL w1_busy got busy=%b done=%b want 1 0", busy1, done1); end
    @(negedge clk);
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL w1_done got %b want 1", done1); end
    checks++; if ({sum1, cout1, ovf1} !== 3'b011) begin errors++; $display("FAIL w1_add got sum=%b c=%b v=%b want 0 1 1", sum1, cout1, ovf1); end
    // 0 - (-1) = 1 is unrepresentable; borrow taken so cout=0.
    a1 = 1'b0; b1 = 1'b1; sub1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    checks++; if (done1 !== 1'b1 || {sum1, cout1, ovf1} !== 3'b101) begin errors++; $display("FAIL w1_sub got done=%b sum=%b c=%b v=%b want 1 1 0 1", done1, sum1, cout1, ovf1); end
    $display("test_width1 complete");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_busy_ignore();
    test_abort();
    test_back_to_back();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
